// File: rtl/core_mem_if.sv
// core_mem_if: fetch/load/store bus between a core and core_mem.
// Ports: mem_addr1/mem_rd_data1 fetch, mem_addr2/mem_rd_data2 load,
// mem_wr_* and mem_byte_en store, halt/halt_code TOHOST status.
interface core_mem_if;
  logic [31:0] mem_addr1;
  logic [31:0] mem_rd_data1;
  logic [31:0] mem_addr2;
  logic [31:0] mem_rd_data2;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic        halt;
  logic [31:0] halt_code;
  modport master (
    output mem_addr1, mem_addr2, mem_wr_en, mem_wr_addr, mem_wr_data, mem_byte_en,
    input  mem_rd_data1, mem_rd_data2, halt, halt_code
  );
  modport slave (
    input  mem_addr1, mem_addr2, mem_wr_en, mem_wr_addr, mem_wr_data, mem_byte_en,
    output mem_rd_data1, mem_rd_data2, halt, halt_code
  );
endinterface

// File: rtl/core_mem.sv
// core_mem: dual-read single-write word RAM with optional TOHOST/cycle-counter MMIO window.
// Ports: clk, rst (async active-high), bus (core_mem_if.slave: fetch port 1,
// byte-aligned load port 2, lane-masked store, halt/halt_code).
// Macro CORE_MEM_MMIO_EN enables the 16-byte MMIO window at MMIO_BASE.
module core_mem #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input logic       clk,
  input logic       rst,
  core_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        in1, in2, inw;
  logic [3:0]  lane;
  logic [31:0] wdat, ram1, ram2, mmio_rd;
  logic        unused_ok;
  assign in1 = bus.mem_addr1[31:AW+2] == '0;
  assign in2 = bus.mem_addr2[31:AW+2] == '0;
  assign inw = bus.mem_wr_addr[31:AW+2] == '0;
  // 4-bit shift drops lanes pushed past lane 3, so a store never spills into the next word
  assign lane = bus.mem_byte_en << bus.mem_wr_addr[1:0];
  assign wdat = bus.mem_wr_data << {bus.mem_wr_addr[1:0], 3'b000};
  assign unused_ok = &{1'b0, bus.mem_addr1[1:0]};
  always_ff @(posedge clk)
    if (!rst && bus.mem_wr_en && inw)
      for (int i = 0; i < 4; i++)
        if (lane[i]) mem_q[bus.mem_wr_addr[AW+1:2]][8*i +: 8] <= wdat[8*i +: 8];
  assign ram1 = in1 ? mem_q[bus.mem_addr1[AW+1:2]] : 32'h0;
  assign ram2 = in2 ? mem_q[bus.mem_addr2[AW+1:2]] >> {bus.mem_addr2[1:0], 3'b000} : 32'h0;
  assign bus.mem_rd_data1 = ram1;
  assign bus.mem_rd_data2 = in2 ? ram2 : mmio_rd;
`ifdef CORE_MEM_MMIO_EN
  logic        halt_q, halt_d, mm2, tohost;
  logic [31:0] code_q, code_d;
  logic [63:0] cyc_q, cyc_d;
  assign mm2    = bus.mem_addr2[31:4] == MMIO_BASE[31:4];
  // only the first TOHOST store counts; later ones are ignored until reset
  assign tohost = bus.mem_wr_en && bus.mem_wr_addr[31:4] == MMIO_BASE[31:4] &&
                  bus.mem_wr_addr[3:2] == 2'd0 && !halt_q;
  always_comb begin
    halt_d = halt_q | tohost;
    code_d = tohost ? bus.mem_wr_data : code_q;
    cyc_d  = halt_d ? cyc_q : cyc_q + 64'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      halt_q <= 1'b0;
      code_q <= '0;
      cyc_q  <= '0;
    end else begin
      halt_q <= halt_d;
      code_q <= code_d;
      cyc_q  <= cyc_d;
    end
  assign mmio_rd = !mm2 ? 32'h0 :
                   bus.mem_addr2[3:2] == 2'd1 ? cyc_q[31:0] :
                   bus.mem_addr2[3:2] == 2'd2 ? cyc_q[63:32] : 32'h0;
  assign bus.halt      = halt_q;
  assign bus.halt_code = code_q;
`else
  assign mmio_rd       = 32'h0;
  assign bus.halt      = 1'b0;
  assign bus.halt_code = 32'h0;
`endif
endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem: directed table, corner sequences and random store/load against a byte-level memory model.
module tb_core_mem;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  core_mem_if bus();
  core_mem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];
  typedef struct {
    logic        we;
    logic [31:0] wa, wd;
    logic [3:0]  be;
    logic [31:0] ra, e1, e2;
  } vec_t;
  vec_t tv [11];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(logic [31:0] a, bit port2);
    if (a >= DEPTH * 4) return 32'h0;
    return port2 ? ref_mem[a / 4] >> (8 * (a % 4)) : ref_mem[a / 4];
  endfunction

  task automatic ref_wr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    int p;
    if (a >= DEPTH * 4) return;
    for (int i = 0; i < 4; i++) begin
      p = int'(a % 4) + i;
      if (be[i] && p < 4) ref_mem[a / 4][8*p +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic drive(logic we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    bus.mem_wr_en   = we;
    bus.mem_wr_addr = a;
    bus.mem_wr_data = d;
    bus.mem_byte_en = be;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    drive(1'b1, a, d, be);
    @(negedge clk);
    ref_wr(a, d, be);
    bus.mem_wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] wa, wd, old;
    logic [3:0]  be;
    logic        we;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    bus.mem_addr1 = 32'h0;
    bus.mem_addr2 = 32'h0;
    #1;
    chk("reset_halt", {31'h0, bus.halt}, 32'h0);
    chk("reset_code", bus.halt_code, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < DEPTH; w++) store(w * 4, $urandom, 4'hF);

    tv[0]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 32'h00, 32'h11223344, 32'h11223344};
    tv[1]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 32'h13, 32'h0000005A, 4'h1, 32'h13, 32'h5AADBEEF, 32'h0000005A};
    tv[3]  = '{1'b0, 32'h00, 32'h00000000, 4'h0, 32'h12, 32'h5AADBEEF, 32'h00005AAD};
    tv[4]  = '{1'b1, 32'h13, 32'h00001234, 4'h3, 32'h10, 32'h34ADBEEF, 32'h34ADBEEF};
    tv[5]  = '{1'b1, DEPTH * 4, 32'hFFFFFFFF, 4'hF, DEPTH * 4, 32'h0, 32'h0};
    tv[6]  = '{1'b0, 32'h00, 32'h00000000, 4'h0, 32'h00, 32'h11223344, 32'h11223344};
    tv[7]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h10, 32'h34ADBEEF, 32'h34ADBEEF};
    tv[8]  = '{1'b1, BASE + 32'hC, 32'hFFFFFFFF, 4'hF, BASE + 32'hC, 32'h0, 32'h0};
    tv[9]  = '{1'b1, 32'h14, 32'h00000000, 4'hF, 32'h14, 32'h0, 32'h0};
    tv[10] = '{1'b1, 32'h17, 32'hAABBCCDD, 4'hF, 32'h14, 32'hDD000000, 32'hDD000000};
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].be);
      @(negedge clk);
      if (tv[i].we) ref_wr(tv[i].wa, tv[i].wd, tv[i].be);
      bus.mem_wr_en = 1'b0;
      bus.mem_addr1 = tv[i].ra;
      bus.mem_addr2 = tv[i].ra;
      #1;
      chk($sformatf("vec%0d rd1", i), bus.mem_rd_data1, tv[i].e1);
      chk($sformatf("vec%0d rd2", i), bus.mem_rd_data2, tv[i].e2);
    end

    drive(1'b1, 32'h10, 32'h01020304, 4'hF);
    bus.mem_addr1 = 32'h10;
    bus.mem_addr2 = 32'h10;
    #1;
    chk("same_cycle_old", bus.mem_rd_data2, 32'h34ADBEEF);
    @(negedge clk);
    ref_wr(32'h10, 32'h01020304, 4'hF);
    bus.mem_wr_en = 1'b0;
    #1;
    chk("after_edge_new1", bus.mem_rd_data1, 32'h01020304);
    chk("after_edge_new2", bus.mem_rd_data2, 32'h01020304);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we = ($urandom % 4) != 0;
      wa = ($urandom % 10 == 0) ? $urandom : $urandom_range(0, DEPTH * 4 + 15);
      wd = $urandom;
      case ($urandom % 4)
        0: be = 4'h1;
        1: be = 4'h3;
        2: be = 4'hF;
        default: be = 4'($urandom);
      endcase
      drive(we, wa, wd, be);
      bus.mem_addr1 = $urandom_range(0, DEPTH * 4 + 15);
      bus.mem_addr2 = $urandom_range(0, DEPTH * 4 + 15);
      #1;
      chk($sformatf("rand%0d rd1 @%h", n, bus.mem_addr1), bus.mem_rd_data1, ref_rd(bus.mem_addr1, 1'b0));
      chk($sformatf("rand%0d rd2 @%h", n, bus.mem_addr2), bus.mem_rd_data2, ref_rd(bus.mem_addr2, 1'b1));
      @(posedge clk);
      if (we) ref_wr(wa, wd, be);
    end
    @(negedge clk);
    bus.mem_wr_en = 1'b0;

    old = ref_mem[8];
    drive(1'b1, 32'h20, ~old, 4'hF);
    bus.mem_addr2 = 32'h20;
    #2 rst = 1'b1;
    #1;
    chk("midrst_halt", {31'h0, bus.halt}, 32'h0);
    chk("midrst_code", bus.halt_code, 32'h0);
    @(negedge clk);
    chk("midrst_store_suppressed", bus.mem_rd_data2, old);
    bus.mem_wr_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("ram_kept_after_rst", bus.mem_rd_data2, old);

`ifdef CORE_MEM_MMIO_EN
    bus.mem_addr1 = BASE + 32'h4;
    bus.mem_addr2 = BASE + 32'h4;
    repeat (100) @(negedge clk);
    chk("cycle_lo_100", bus.mem_rd_data2, 32'd100);
    chk("port1_mmio_zero", bus.mem_rd_data1, 32'h0);
    bus.mem_addr2 = BASE + 32'h8;
    #1;
    chk("cycle_hi_0", bus.mem_rd_data2, 32'h0);
    bus.mem_addr2 = BASE + 32'h4;
    drive(1'b1, BASE, 32'h1, 4'hF);
    @(negedge clk);
    chk("tohost_halt", {31'h0, bus.halt}, 32'h1);
    chk("tohost_code", bus.halt_code, 32'h1);
    chk("cycle_frozen_at_halt", bus.mem_rd_data2, 32'd100);
    drive(1'b1, BASE, 32'h2, 4'hF);
    @(negedge clk);
    bus.mem_wr_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("second_tohost_ignored", bus.halt_code, 32'h1);
    chk("cycle_still_frozen", bus.mem_rd_data2, 32'd100);
    #2 rst = 1'b1;
    #1;
    chk("rst_clears_halt", {31'h0, bus.halt}, 32'h0);
    chk("rst_clears_code", bus.halt_code, 32'h0);
    chk("rst_clears_cycle", bus.mem_rd_data2, 32'h0);
    drive(1'b1, BASE, 32'h7, 4'hF);
    @(negedge clk);
    chk("tohost_under_rst", {31'h0, bus.halt}, 32'h0);
    bus.mem_wr_en = 1'b0;
    rst = 1'b0;
`else
    drive(1'b1, BASE, 32'h1, 4'hF);
    @(negedge clk);
    bus.mem_wr_en = 1'b0;
    bus.mem_addr2 = BASE + 32'h4;
    #1;
    chk("no_mmio_halt", {31'h0, bus.halt}, 32'h0);
    chk("no_mmio_code", bus.halt_code, 32'h0);
    chk("no_mmio_cycle", bus.mem_rd_data2, 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
